// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, flag layout
// and opcode classification helpers.
package alu_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_OR  = 8'h05;
    localparam logic [7:0] OP_XOR = 8'h06;
    localparam logic [7:0] OP_INC = 8'h07;
    localparam logic [7:0] OP_DEC = 8'h08;
    localparam logic [7:0] OP_ROR = 8'h09;
    localparam logic [7:0] OP_ROL = 8'h0A;
    localparam logic [7:0] OP_RSH = 8'h0B;
    localparam logic [7:0] OP_LSH = 8'h0C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

    localparam int FLAG_C  = 0;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_P  = 2;
    localparam int FLAG_EQ = 3;
    localparam int FLAG_GT = 4;
    localparam int FLAG_W  = 5;

    function automatic logic writes_carry(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_RSH) || (op == OP_LSH);
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        return op <= OP_LSH;
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural flag register; loads on capture, with carry only written when
// the executing opcode produces a meaningful carry.
module alu_flag_reg
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_carry_we,
    input  logic [FLAG_W-1:0] i_flags,
    output logic [FLAG_W-1:0] o_flags
);

    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] w_flags_next;

    always_comb begin
        w_flags_next         = i_flags;
        w_flags_next[FLAG_C] = i_carry_we ? i_flags[FLAG_C] : r_flags[FLAG_C];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
        end else if (i_capture) begin
            r_flags <= w_flags_next;
        end
    end

    assign o_flags = r_flags;

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue ALU controller: latches a request, holds the ALU inputs for an
// opcode-dependent number of cycles, then registers the result and flags.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int MUL_CYCLES  = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_instruction,
    input  logic [15:0] req_op1,
    input  logic [15:0] req_op2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_illegal,
    output logic [7:0]  alu_instruction,
    output logic [15:0] alu_op1,
    output logic [15:0] alu_op2,
    input  logic [15:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_parity,
    input  logic        alu_eq,
    input  logic        alu_gt,
    output logic        flag_carry,
    output logic        flag_zero,
    output logic        flag_parity,
    output logic        flag_eq,
    output logic        flag_gt,
    output logic        busy
);

    localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_CYCLES - 1);

    state_e            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_alu_instr;
    logic [15:0]       r_op1, r_op2, r_rsp_result;
    logic              r_rsp_illegal, r_skip;
    logic              w_accept, w_capture, w_skip_req;
    logic [15:0]       w_result;
    logic [FLAG_W-1:0] w_flags_in, w_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOP/illegal spend their single cycle in EXEC with the ALU left at NOP,
    // giving the same one-cycle response latency as simple ops.
    assign w_skip_req = (req_instruction == OP_NOP) || !is_legal(req_instruction);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_alu_instr   <= OP_NOP;
            r_op1         <= '0;
            r_op2         <= '0;
            r_rsp_result  <= '0;
            r_rsp_illegal <= 1'b0;
            r_skip        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_skip        <= w_skip_req;
                r_rsp_illegal <= !is_legal(req_instruction);
                if (w_skip_req) begin
                    r_cnt <= '0;
                end else begin
                    r_alu_instr <= req_instruction;
                    r_op1       <= req_op1;
                    r_op2       <= req_op2;
                    r_cnt       <= (req_instruction == OP_MUL) ? MUL_LOAD : EXEC_LOAD;
                end
            end else if (r_state == ST_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rsp_result <= r_skip ? 16'h0000 : w_result;
                r_alu_instr  <= OP_NOP;
            end
        end
    end

    assign w_result = (r_alu_instr == OP_MUL) ? alu_out : {8'h00, alu_out[7:0]};

    always_comb begin
        w_flags_in          = '0;
        w_flags_in[FLAG_C]  = alu_carry;
        w_flags_in[FLAG_Z]  = (w_result == 16'h0000);
        w_flags_in[FLAG_P]  = alu_parity;
        w_flags_in[FLAG_EQ] = alu_eq;
        w_flags_in[FLAG_GT] = alu_gt;
    end

    alu_flag_reg u_flag_reg (
        .clk        (clk),
        .rst        (rst),
        .i_capture  (w_capture && !r_skip),
        .i_carry_we (writes_carry(r_alu_instr)),
        .i_flags    (w_flags_in),
        .o_flags    (w_flags)
    );

    assign rsp_result      = r_rsp_result;
    assign rsp_illegal     = r_rsp_illegal;
    assign alu_instruction = r_alu_instr;
    assign alu_op1         = r_op1;
    assign alu_op2         = r_op2;
    assign flag_carry      = w_flags[FLAG_C];
    assign flag_zero       = w_flags[FLAG_Z];
    assign flag_parity     = w_flags[FLAG_P];
    assign flag_eq         = w_flags[FLAG_EQ];
    assign flag_gt         = w_flags[FLAG_GT];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU attached to
// the sequencer's ALU-side ports.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [7:0]  req_instruction;
    logic [15:0] req_op1, req_op2;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_illegal;
    logic [7:0]  alu_instruction;
    logic [15:0] alu_op1, alu_op2, alu_out;
    logic        alu_carry, alu_parity, alu_eq, alu_gt;
    logic        flag_carry, flag_zero, flag_parity, flag_eq, flag_gt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_instruction (req_instruction),
        .req_op1         (req_op1),
        .req_op2         (req_op2),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_illegal     (rsp_illegal),
        .alu_instruction (alu_instruction),
        .alu_op1         (alu_op1),
        .alu_op2         (alu_op2),
        .alu_out         (alu_out),
        .alu_carry       (alu_carry),
        .alu_parity      (alu_parity),
        .alu_eq          (alu_eq),
        .alu_gt          (alu_gt),
        .flag_carry      (flag_carry),
        .flag_zero       (flag_zero),
        .flag_parity     (flag_parity),
        .flag_eq         (flag_eq),
        .flag_gt         (flag_gt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: only the opcodes this bench exercises produce results.
    always_comb begin
        logic [8:0] w_sum;
        w_sum     = '0;
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_instruction)
            8'h01: begin w_sum = {1'b0, alu_op1[7:0]} + {1'b0, alu_op2[7:0]}; alu_out = {7'b0, w_sum}; alu_carry = w_sum[8]; end
            8'h02: begin w_sum = {1'b0, alu_op1[7:0]} - {1'b0, alu_op2[7:0]}; alu_out = {7'b0, w_sum}; alu_carry = w_sum[8]; end
            8'h03: alu_out = alu_op1[7:0] * alu_op2[7:0];
            8'h04: alu_out = {8'h00, alu_op1[7:0] & alu_op2[7:0]};
            default: alu_out = '0;
        endcase
        alu_parity = ^alu_out[7:0];
        alu_eq     = (alu_op1[7:0] == alu_op2[7:0]);
        alu_gt     = (alu_op1[7:0] >  alu_op2[7:0]);
    end

    function automatic logic [15:0] flags16();
        return {11'b0, flag_gt, flag_eq, flag_parity, flag_zero, flag_carry};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        req_valid       = 1'b1;
        req_instruction = op;
        req_op1         = a;
        req_op2         = b;
        cyc();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_res;
        int accepts, resps;

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_instruction = '0; req_op1 = '0; req_op2 = '0;
        cyc(); cyc();
        check("reset_busy",   {15'b0, busy}, 16'h0);
        check("reset_ready",  {15'b0, req_ready}, 16'h1);
        check("reset_valid",  {15'b0, rsp_valid}, 16'h0);
        check("reset_flags",  flags16(), 16'h0);
        check("reset_instr",  {8'h00, alu_instruction}, 16'h0);
        rst = 1'b0;
        cyc();

        // ADD 0xF0 + 0x20: one-cycle latency, carry out, then held in DONE
        request(8'h01, 16'h00F0, 16'h0020);
        check("add_t_instr",  {8'h00, alu_instruction}, 16'h0001);
        check("add_t_op1",    alu_op1, 16'h00F0);
        check("add_t_valid",  {15'b0, rsp_valid}, 16'h0);
        check("add_t_busy",   {15'b0, busy}, 16'h1);
        cyc();
        check("add_valid",    {15'b0, rsp_valid}, 16'h1);
        check("add_result",   rsp_result, 16'h0010);
        check("add_flags",    flags16(), 16'h0015);
        check("add_nop_back", {8'h00, alu_instruction}, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("add_hold_result", rsp_result, 16'h0010);
            check("add_hold_flags",  flags16(), 16'h0015);
            check("add_hold_ready",  {15'b0, req_ready}, 16'h0);
        end
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
        check("add_release", {15'b0, rsp_valid}, 16'h0);

        // AND 0xFF,0x00: zero set, carry held from the ADD
        request(8'h04, 16'h00FF, 16'h0000);
        cyc();
        check("and_result",  rsp_result, 16'h0000);
        check("and_flags",   flags16(), 16'h0013);
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;

        // MUL 0x10 * 0x10: inputs held two cycles, full 16-bit result
        request(8'h03, 16'h0010, 16'h0010);
        check("mul_t_instr",  {8'h00, alu_instruction}, 16'h0003);
        check("mul_t_valid",  {15'b0, rsp_valid}, 16'h0);
        cyc();
        check("mul_t1_instr", {8'h00, alu_instruction}, 16'h0003);
        check("mul_t1_op1",   alu_op1, 16'h0010);
        check("mul_t1_op2",   alu_op2, 16'h0010);
        check("mul_t1_valid", {15'b0, rsp_valid}, 16'h0);
        cyc();
        check("mul_valid",    {15'b0, rsp_valid}, 16'h1);
        check("mul_result",   rsp_result, 16'h0100);
        check("mul_flags",    flags16(), 16'h0009);
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;

        // Illegal opcode 0x1F: one-cycle response, flags untouched
        request(8'h1F, 16'h1234, 16'h5678);
        check("ill_t_instr", {8'h00, alu_instruction}, 16'h0000);
        check("ill_t_valid", {15'b0, rsp_valid}, 16'h0);
        cyc();
        check("ill_valid",   {15'b0, rsp_valid}, 16'h1);
        check("ill_illegal", {15'b0, rsp_illegal}, 16'h1);
        check("ill_result",  rsp_result, 16'h0000);
        check("ill_flags",   flags16(), 16'h0009);
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;

        // NOP: legal, zero result, flags untouched
        request(8'h00, 16'h00AA, 16'h0055);
        cyc();
        check("nop_valid",   {15'b0, rsp_valid}, 16'h1);
        check("nop_illegal", {15'b0, rsp_illegal}, 16'h0);
        check("nop_result",  rsp_result, 16'h0000);
        check("nop_flags",   flags16(), 16'h0009);
        rsp_ready = 1'b1; cyc();

        // Back-to-back ADDs with both handshakes always asserted
        accepts = 0; resps = 0;
        req_valid = 1'b1; req_instruction = 8'h01; req_op1 = 16'h0001; req_op2 = 16'h0010;
        for (int i = 0; i < 9; i++) begin
            logic fire;
            fire = req_valid && req_ready;
            cyc();
            if (fire) begin
                accepts++;
                req_op1 = req_op1 + 16'h1;
            end
            if (rsp_valid) begin
                resps++;
                exp_res = 16'h0010 + 16'(resps);
                check("b2b_result", rsp_result, exp_res);
            end
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        check("b2b_accepts", 16'(accepts), 16'd3);
        check("b2b_resps",   16'(resps),   16'd3);

        // Reset in the middle of a MUL clears everything asynchronously
        request(8'h03, 16'h0007, 16'h0009);
        rst = 1'b1;
        #1;
        check("rst_async_busy",  {15'b0, busy}, 16'h0);
        check("rst_async_instr", {8'h00, alu_instruction}, 16'h0000);
        check("rst_async_op1",   alu_op1, 16'h0000);
        check("rst_async_flags", flags16(), 16'h0000);
        check("rst_async_res",   rsp_result, 16'h0000);
        cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        check("rst_after_valid", {15'b0, rsp_valid}, 16'h0);
        check("rst_after_ready", {15'b0, req_ready}, 16'h1);
        check("rst_after_flags", flags16(), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
